// File: rtl/ili9341_defines.sv
// Shared ILI9341 command codes and the decoder state type for the SPI responder.
package ili9341_defines;

   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_SLPIN   = 8'h10;
   localparam logic [7:0] CMD_SLPOUT  = 8'h11;
   localparam logic [7:0] CMD_DISPOFF = 8'h28;
   localparam logic [7:0] CMD_DISPON  = 8'h29;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_PASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;

   typedef enum logic [3:0] {
      IDLE,
      COL_P0, COL_P1, COL_P2, COL_P3,
      PAGE_P0, PAGE_P1, PAGE_P2, PAGE_P3,
      RAM_HI, RAM_LO,
      SKIP
   } ili9341_rx_state_t;

endpackage

// File: rtl/spi_peripheral_rx.sv
// SPI mode-0 byte receiver: 2-flop synchronisers, spi_clk rise detect, MSB-first shifter.
module spi_peripheral_rx (
   input  logic       clk,
   input  logic       rstb,
   input  logic       spi_csb,
   input  logic       spi_clk,
   input  logic       spi_mosi,
   input  logic       data_commandb,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       byte_dc
);

   logic [1:0] csb_sync;
   logic [1:0] sck_sync;
   logic [1:0] mosi_sync;
   logic [1:0] dc_sync;
   logic       sck_prev;
   logic [2:0] bit_cnt;
   logic [6:0] shift;
   logic       sck_rise;

   assign sck_rise = sck_sync[1] & ~sck_prev & ~csb_sync[1];

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         csb_sync   <= 2'b11;
         sck_sync   <= '0;
         mosi_sync  <= '0;
         dc_sync    <= '0;
         sck_prev   <= 1'b0;
         bit_cnt    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         rx_byte    <= '0;
         byte_dc    <= 1'b0;
      end else begin
         csb_sync   <= {csb_sync[0], spi_csb};
         sck_sync   <= {sck_sync[0], spi_clk};
         mosi_sync  <= {mosi_sync[0], spi_mosi};
         dc_sync    <= {dc_sync[0], data_commandb};
         sck_prev   <= sck_sync[1];
         byte_valid <= 1'b0;
         // A deasserted select drops the partial byte; the shifter is simply overwritten later.
         if (csb_sync[1]) begin
            bit_cnt <= '0;
         end else if (sck_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_valid <= 1'b1;
               rx_byte    <= {shift, mosi_sync[1]};
               byte_dc    <= dc_sync[1];
            end else begin
               shift <= {shift[5:0], mosi_sync[1]};
            end
         end
      end
   end

endmodule

// File: rtl/ili9341_spi_responder.sv
// Device-side ILI9341 SPI write decoder: commands, address window and addressed RGB565 pixel stream.
//   state   | meaning
//   IDLE    | no command in progress, data ignored
//   COL_P*  | collecting CASET start hi/lo, end hi/lo
//   PAGE_P* | collecting PASET start hi/lo, end hi/lo
//   RAM_HI  | waiting for pixel high byte
//   RAM_LO  | waiting for pixel low byte
//   SKIP    | unsupported command, data ignored
module ili9341_spi_responder
   import ili9341_defines::*;
#(
   parameter int DISPLAY_WIDTH  = 240,
   parameter int DISPLAY_HEIGHT = 320,
   parameter int COORD_W = $clog2((DISPLAY_WIDTH > DISPLAY_HEIGHT) ? DISPLAY_WIDTH : DISPLAY_HEIGHT)
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               spi_csb,
   input  logic               spi_clk,
   input  logic               spi_mosi,
   input  logic               data_commandb,
   output logic               spi_miso,
   output logic               cmd_valid,
   output logic [7:0]         cmd_byte,
   output logic               pixel_valid,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic [15:0]        pixel_data,
   output logic               frame_start,
   output logic               display_on,
   output logic               sleeping,
   output logic               window_err
);

   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(DISPLAY_WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(DISPLAY_HEIGHT - 1);

   logic              byte_valid;
   logic [7:0]        rx_byte;
   logic              byte_dc;
   ili9341_rx_state_t state_q, state_d;
   logic [COORD_W-1:0] sc, ec, sp, ep, x, y;
   logic [COORD_W-1:0] new_start, new_end;
   logic [7:0]        p0, p1, p2, pix_hi;
   logic              on_screen;

   assign spi_miso = 1'b0;

   spi_peripheral_rx u_rx (
      .clk           (clk),
      .rstb          (rstb),
      .spi_csb       (spi_csb),
      .spi_clk       (spi_clk),
      .spi_mosi      (spi_mosi),
      .data_commandb (data_commandb),
      .byte_valid    (byte_valid),
      .rx_byte       (rx_byte),
      .byte_dc       (byte_dc)
   );

   assign new_start = COORD_W'({p0, p1});
   assign new_end   = COORD_W'({p2, rx_byte});
   assign on_screen = (int'(x) < DISPLAY_WIDTH) && (int'(y) < DISPLAY_HEIGHT);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (byte_valid) begin
         if (!byte_dc) begin
            case (rx_byte)
               CMD_CASET: state_d = COL_P0;
               CMD_PASET: state_d = PAGE_P0;
               CMD_RAMWR: state_d = RAM_HI;
               CMD_SWRESET, CMD_SLPIN, CMD_SLPOUT, CMD_DISPOFF, CMD_DISPON: state_d = IDLE;
               default:   state_d = SKIP;
            endcase
         end else begin
            case (state_q)
               COL_P0:  state_d = COL_P1;
               COL_P1:  state_d = COL_P2;
               COL_P2:  state_d = COL_P3;
               COL_P3:  state_d = IDLE;
               PAGE_P0: state_d = PAGE_P1;
               PAGE_P1: state_d = PAGE_P2;
               PAGE_P2: state_d = PAGE_P3;
               PAGE_P3: state_d = IDLE;
               RAM_HI:  state_d = RAM_LO;
               RAM_LO:  state_d = RAM_HI;
               default: state_d = state_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cmd_valid   <= 1'b0;
         cmd_byte    <= '0;
         pixel_valid <= 1'b0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         pixel_data  <= '0;
         frame_start <= 1'b0;
         display_on  <= 1'b0;
         sleeping    <= 1'b1;
         window_err  <= 1'b0;
         sc <= '0;  ec <= X_MAX;
         sp <= '0;  ep <= Y_MAX;
         x  <= '0;  y  <= '0;
         p0 <= '0;  p1 <= '0;  p2 <= '0;  pix_hi <= '0;
      end else begin
         cmd_valid   <= 1'b0;
         pixel_valid <= 1'b0;
         frame_start <= 1'b0;
         window_err  <= 1'b0;
         if (byte_valid && !byte_dc) begin
            cmd_valid <= 1'b1;
            cmd_byte  <= rx_byte;
            case (rx_byte)
               CMD_RAMWR: begin
                  x <= sc;
                  y <= sp;
                  frame_start <= 1'b1;
               end
               CMD_SWRESET: begin
                  sc <= '0;  ec <= X_MAX;
                  sp <= '0;  ep <= Y_MAX;
                  display_on <= 1'b0;
                  sleeping   <= 1'b1;
               end
               CMD_SLPIN:   sleeping   <= 1'b1;
               CMD_SLPOUT:  sleeping   <= 1'b0;
               CMD_DISPOFF: display_on <= 1'b0;
               CMD_DISPON:  display_on <= 1'b1;
               default: ;
            endcase
         end else if (byte_valid) begin
            case (state_q)
               COL_P0, PAGE_P0: p0 <= rx_byte;
               COL_P1, PAGE_P1: p1 <= rx_byte;
               COL_P2, PAGE_P2: p2 <= rx_byte;
               COL_P3: begin
                  if (new_start <= new_end) begin
                     sc <= new_start;
                     ec <= new_end;
                  end else begin
                     window_err <= 1'b1;
                  end
               end
               PAGE_P3: begin
                  if (new_start <= new_end) begin
                     sp <= new_start;
                     ep <= new_end;
                  end else begin
                     window_err <= 1'b1;
                  end
               end
               RAM_HI: pix_hi <= rx_byte;
               RAM_LO: begin
                  // Coordinates and data update for every pixel; only on-screen ones strobe.
                  pixel_x     <= x;
                  pixel_y     <= y;
                  pixel_data  <= {pix_hi, rx_byte};
                  pixel_valid <= on_screen;
                  if (x == ec) begin
                     x <= sc;
                     y <= (y == ep) ? sp : y + COORD_W'(1);
                  end else begin
                     x <= x + COORD_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ili9341_spi_responder.sv
// Self-checking bench: a 32x32 instance checked against a window/pixel-index model, plus a default-size instance for off-screen clipping.
module tb_ili9341_spi_responder;
   import ili9341_defines::*;

   logic clk = 1'b0;
   logic rstb = 1'b0;
   logic csb = 1'b1, sclk = 1'b0, mosi = 1'b0, dcb = 1'b0;

   logic        miso, cmd_valid, pixel_valid, frame_start, display_on, sleeping, window_err;
   logic [7:0]  cmd_byte;
   logic [4:0]  pixel_x, pixel_y;
   logic [15:0] pixel_data;
   logic        miso_d, cmd_valid_d, pixel_valid_d, frame_start_d, display_on_d, sleeping_d, window_err_d;
   logic [7:0]  cmd_byte_d;
   logic [8:0]  pixel_x_d, pixel_y_d;
   logic [15:0] pixel_data_d;

   always #5 clk = ~clk;

   ili9341_spi_responder #(.DISPLAY_WIDTH(32), .DISPLAY_HEIGHT(32)) dut (
      .clk(clk), .rstb(rstb), .spi_csb(csb), .spi_clk(sclk), .spi_mosi(mosi),
      .data_commandb(dcb), .spi_miso(miso), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
      .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_data(pixel_data),
      .frame_start(frame_start), .display_on(display_on), .sleeping(sleeping), .window_err(window_err)
   );

   ili9341_spi_responder dut_d (
      .clk(clk), .rstb(rstb), .spi_csb(csb), .spi_clk(sclk), .spi_mosi(mosi),
      .data_commandb(dcb), .spi_miso(miso_d), .cmd_valid(cmd_valid_d), .cmd_byte(cmd_byte_d),
      .pixel_valid(pixel_valid_d), .pixel_x(pixel_x_d), .pixel_y(pixel_y_d), .pixel_data(pixel_data_d),
      .frame_start(frame_start_d), .display_on(display_on_d), .sleeping(sleeping_d), .window_err(window_err_d)
   );

   int total = 0, bad = 0;
   int n_cmd = 0, n_frame = 0, n_err = 0, n_pix_d = 0;
   logic [25:0] pix_q[$];

   // Reference model: window bounds plus the index of the next pixel since RAMWR.
   int m_sc = 0, m_ec = 31, m_sp = 0, m_ep = 31, m_n = 0, m_err = 0;

   always @(negedge clk) begin
      if (cmd_valid)   n_cmd++;
      if (frame_start) n_frame++;
      if (window_err)  n_err++;
      if (pixel_valid) pix_q.push_back({pixel_x, pixel_y, pixel_data});
      if (pixel_valid_d) n_pix_d++;
   end

   task automatic spi_bits(input logic [7:0] b, input logic dc, input int nbits);
      csb = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = b[i];
         dcb  = dc;
         repeat (4) @(negedge clk);
         sclk = 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (2) @(negedge clk);
      csb = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic dc);
      spi_bits(b, dc, 8);
   endtask

   task automatic set_window(input bit col, input logic [15:0] s, input logic [15:0] e);
      send_byte(col ? CMD_CASET : CMD_PASET, 1'b0);
      send_byte(s[15:8], 1'b1);
      send_byte(s[7:0], 1'b1);
      send_byte(e[15:8], 1'b1);
      send_byte(e[7:0], 1'b1);
      if (s <= e) begin
         if (col) begin m_sc = int'(s); m_ec = int'(e); end
         else     begin m_sp = int'(s); m_ep = int'(e); end
      end else begin
         m_err++;
      end
   endtask

   task automatic ramwr();
      send_byte(CMD_RAMWR, 1'b0);
      m_n = 0;
   endtask

   // Sends one pixel and returns where the model expects it to land.
   task automatic send_pixel(input logic [15:0] d, output logic [25:0] expv);
      int w, h, ex, ey;
      w  = m_ec - m_sc + 1;
      h  = m_ep - m_sp + 1;
      ex = m_sc + (m_n % w);
      ey = m_sp + ((m_n / w) % h);
      expv = {ex[4:0], ey[4:0], d};
      m_n++;
      send_byte(d[15:8], 1'b1);
      send_byte(d[7:0], 1'b1);
   endtask

   task automatic test_reset();
      rstb = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (cmd_valid !== 1'b0 || pixel_valid !== 1'b0 || frame_start !== 1'b0 || window_err !== 1'b0) begin
         bad++; $display("FAIL reset_strobes got=%b%b%b%b want=0000", cmd_valid, pixel_valid, frame_start, window_err); end
      total++; if (cmd_byte !== 8'h00) begin bad++; $display("FAIL reset_cmd_byte got=%h want=00", cmd_byte); end
      total++; if ({pixel_x, pixel_y, pixel_data} !== 26'd0) begin
         bad++; $display("FAIL reset_pixel got=%0d,%0d,%h want=0,0,0000", pixel_x, pixel_y, pixel_data); end
      total++; if (display_on !== 1'b0 || sleeping !== 1'b1) begin
         bad++; $display("FAIL reset_flags got on=%b sleep=%b want on=0 sleep=1", display_on, sleeping); end
      total++; if (miso !== 1'b0) begin bad++; $display("FAIL miso got=%b want=0", miso); end
      rstb = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_power();
      int c0;
      c0 = n_cmd;
      send_byte(CMD_DISPON, 1'b0);
      total++; if (n_cmd - c0 !== 1) begin bad++; $display("FAIL dispon_cmd_valid got=%0d want=1", n_cmd - c0); end
      total++; if (cmd_byte !== 8'h29) begin bad++; $display("FAIL dispon_cmd_byte got=%h want=29", cmd_byte); end
      total++; if (display_on !== 1'b1 || sleeping !== 1'b1) begin
         bad++; $display("FAIL dispon_flags got on=%b sleep=%b want on=1 sleep=1", display_on, sleeping); end
      send_byte(CMD_SLPOUT, 1'b0);
      total++; if (sleeping !== 1'b0) begin bad++; $display("FAIL slpout got=%b want=0", sleeping); end
      send_byte(CMD_DISPOFF, 1'b0);
      total++; if (display_on !== 1'b0) begin bad++; $display("FAIL dispoff got=%b want=0", display_on); end
      send_byte(CMD_SLPIN, 1'b0);
      total++; if (sleeping !== 1'b1) begin bad++; $display("FAIL slpin got=%b want=1", sleeping); end
   endtask

   task automatic test_window_stream();
      logic [25:0] want[3];
      logic [25:0] e;
      int f0;
      want[0] = {5'd2, 5'd5, 16'hF800};
      want[1] = {5'd3, 5'd5, 16'h07E0};
      want[2] = {5'd2, 5'd5, 16'h001F};
      pix_q.delete();
      set_window(1'b1, 16'd2, 16'd3);
      set_window(1'b0, 16'd5, 16'd5);
      f0 = n_frame;
      ramwr();
      send_pixel(16'hF800, e);
      send_pixel(16'h07E0, e);
      send_pixel(16'h001F, e);
      total++; if (n_frame - f0 !== 1) begin bad++; $display("FAIL stream_frame_start got=%0d want=1", n_frame - f0); end
      total++; if (pix_q.size() !== 3) begin bad++; $display("FAIL stream_count got=%0d want=3", pix_q.size()); end
      for (int i = 0; i < 3 && i < pix_q.size(); i++) begin
         total++; if (pix_q[i] !== want[i]) begin
            bad++; $display("FAIL stream_pixel%0d got=%h want=%h", i, pix_q[i], want[i]); end
      end
   endtask

   task automatic test_window_err();
      logic [25:0] e;
      int e0;
      e0 = n_err;
      pix_q.delete();
      set_window(1'b1, 16'd8, 16'd4);
      total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL caset_err got=%0d want=1", n_err - e0); end
      ramwr();
      send_pixel(16'hBEEF, e);
      total++; if (pix_q.size() !== 1 || pix_q[0] !== {5'd2, 5'd5, 16'hBEEF}) begin
         bad++; $display("FAIL caset_err_keep got=%h n=%0d want=%h", (pix_q.size() > 0) ? pix_q[0] : 26'd0, pix_q.size(), {5'd2, 5'd5, 16'hBEEF}); end
   endtask

   task automatic test_half_pixel();
      pix_q.delete();
      ramwr();
      send_byte(8'hAB, 1'b1);
      send_byte(8'h00, 1'b0);
      ramwr();
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      total++; if (pix_q.size() !== 1 || pix_q[0] !== {5'd2, 5'd5, 16'h1234}) begin
         bad++; $display("FAIL half_pixel got=%h n=%0d want=%h", (pix_q.size() > 0) ? pix_q[0] : 26'd0, pix_q.size(), {5'd2, 5'd5, 16'h1234}); end
      m_n = 1;
   endtask

   task automatic test_partial_csb();
      int c0;
      c0 = n_cmd;
      spi_bits(8'hFF, 1'b0, 5);
      send_byte(CMD_RAMWR, 1'b0);
      m_n = 0;
      total++; if (n_cmd - c0 !== 1) begin bad++; $display("FAIL partial_cmd_count got=%0d want=1", n_cmd - c0); end
      total++; if (cmd_byte !== 8'h2C) begin bad++; $display("FAIL partial_cmd_byte got=%h want=2C", cmd_byte); end
   endtask

   task automatic test_random();
      logic [25:0] exp_q[$];
      logic [25:0] e;
      int npx, e0;
      for (int r = 0; r < 6; r++) begin
         exp_q.delete();
         pix_q.delete();
         e0 = m_err - n_err;
         set_window(1'b1, 16'($urandom_range(0, 31)), 16'($urandom_range(0, 31)));
         set_window(1'b0, 16'($urandom_range(0, 31)), 16'($urandom_range(0, 31)));
         total++; if (m_err - n_err !== e0) begin
            bad++; $display("FAIL rand%0d_window_err got=%0d want=%0d", r, n_err, m_err - e0); end
         ramwr();
         npx = $urandom_range(1, 8);
         for (int i = 0; i < npx; i++) begin
            send_pixel(16'($urandom), e);
            exp_q.push_back(e);
         end
         total++; if (pix_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL rand%0d_count got=%0d want=%0d", r, pix_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < pix_q.size(); i++) begin
            total++; if (pix_q[i] !== exp_q[i]) begin
               bad++; $display("FAIL rand%0d_pixel%0d got=%h want=%h", r, i, pix_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_offscreen();
      logic [25:0] e;
      int p0;
      set_window(1'b1, 16'd300, 16'd319);
      set_window(1'b0, 16'd0, 16'd0);
      ramwr();
      p0 = n_pix_d;
      send_pixel(16'h1111, e);
      total++; if (n_pix_d !== p0 || pixel_x_d !== 9'd300) begin
         bad++; $display("FAIL offscreen_300 got valid=%0d x=%0d want valid=0 x=300", n_pix_d - p0, pixel_x_d); end
      send_pixel(16'h2222, e);
      total++; if (n_pix_d !== p0 || pixel_x_d !== 9'd301) begin
         bad++; $display("FAIL offscreen_301 got valid=%0d x=%0d want valid=0 x=301", n_pix_d - p0, pixel_x_d); end
      set_window(1'b1, 16'd239, 16'd240);
      ramwr();
      send_pixel(16'h3333, e);
      total++; if (n_pix_d - p0 !== 1 || pixel_x_d !== 9'd239 || pixel_data_d !== 16'h3333) begin
         bad++; $display("FAIL edge_239 got valid=%0d x=%0d d=%h want valid=1 x=239 d=3333", n_pix_d - p0, pixel_x_d, pixel_data_d); end
      send_pixel(16'h4444, e);
      total++; if (n_pix_d - p0 !== 1 || pixel_x_d !== 9'd240) begin
         bad++; $display("FAIL edge_240 got valid=%0d x=%0d want valid=1 x=240", n_pix_d - p0, pixel_x_d); end
   endtask

   task automatic test_reset_mid();
      logic [25:0] e;
      int c0, f0, r0;
      send_byte(CMD_DISPON, 1'b0);
      ramwr();
      send_byte(8'h55, 1'b1);
      csb = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         mosi = 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
      end
      #3 rstb = 1'b0;
      #1;
      total++; if (display_on !== 1'b0 || sleeping !== 1'b1 || cmd_byte !== 8'h00 || {pixel_x, pixel_y, pixel_data} !== 26'd0) begin
         bad++; $display("FAIL midreset_outputs got on=%b sleep=%b cmd=%h px=%h want on=0 sleep=1 cmd=00 px=0",
                         display_on, sleeping, cmd_byte, {pixel_x, pixel_y, pixel_data}); end
      total++; if (display_on_d !== 1'b0 || pixel_x_d !== 9'd0 || pixel_data_d !== 16'h0) begin
         bad++; $display("FAIL midreset_default got on=%b x=%0d d=%h want on=0 x=0 d=0000", display_on_d, pixel_x_d, pixel_data_d); end
      csb  = 1'b1;
      mosi = 1'b0;
      repeat (3) @(negedge clk);
      c0 = n_cmd; f0 = n_frame; r0 = n_err;
      pix_q.delete();
      rstb = 1'b1;
      repeat (20) @(negedge clk);
      total++; if (n_cmd !== c0 || n_frame !== f0 || n_err !== r0 || pix_q.size() !== 0) begin
         bad++; $display("FAIL reset_exit_strobes got cmd=%0d frame=%0d err=%0d pix=%0d want 0 0 0 0",
                         n_cmd - c0, n_frame - f0, n_err - r0, pix_q.size()); end
      m_sc = 0; m_ec = 31; m_sp = 0; m_ep = 31;
      ramwr();
      send_pixel(16'h0F0F, e);
      total++; if (pix_q.size() !== 1 || pix_q[0] !== e) begin
         bad++; $display("FAIL post_reset_pixel got=%h n=%0d want=%h", (pix_q.size() > 0) ? pix_q[0] : 26'd0, pix_q.size(), e); end
   endtask

   initial begin
      test_reset();
      test_power();
      test_window_stream();
      test_window_err();
      test_half_pixel();
      test_partial_csb();
      test_random();
      test_offscreen();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
